// File: rtl/alu_seq_param.sv
// Parametrised ALU: logic/arith ops finish in 1 cycle, RSH/LSH shift 1 bit/cycle (1+k cycles).
// No backpressure: start is only accepted in IDLE and is dropped while busy.
module alu_seq_param #(
    parameter int W  = 8,
    parameter int SW = $clog2(W) + 1
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         equal,
    output logic         illegal
);

    localparam logic [3:0] OP_RSH = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_BRE = 4'b0100;
    localparam logic [3:0] OP_LSH = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_CLR = 4'b0111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SW-1:0] W_CNT = SW'(W);

    logic [1:0]    state_q, state_d;
    logic          left_q, left_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          zero_q, zero_d;
    logic          equal_q, equal_d;
    logic          illegal_q, illegal_d;

    logic [SW-1:0] amt;
    logic [SW-1:0] amt_clamped;
    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [W-1:0]  res_n;
    logic          cout_n;
    logic          is_shift;
    logic [W-1:0]  shifted;
    logic          shift_out;

    assign amt         = b[SW-1:0];
    assign amt_clamped = (amt > W_CNT) ? W_CNT : amt;
    assign sum         = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign diff        = {1'b0, a} - {1'b0, b};
    assign is_shift    = (op == OP_RSH) || (op == OP_LSH);

    // Single-cycle datapath; a zero-amount shift degenerates to a pass-through of a.
    always_comb begin
        res_n  = '0;
        cout_n = 1'b0;
        case (op)
            OP_XOR:         res_n = a ^ b;
            OP_ADD:         {cout_n, res_n} = sum;
            OP_AND:         res_n = a & b;
            OP_BRE:         res_n = a ^ b;
            OP_SUB: begin
                res_n  = diff[W-1:0];
                cout_n = diff[W];
            end
            OP_RSH, OP_LSH: res_n = a;
            default:        res_n = '0;
        endcase
    end

    always_comb begin
        shifted   = '0;
        shift_out = 1'b0;
        if (left_q) begin
            shifted   = {result_q[W-2:0], 1'b0};
            shift_out = result_q[W-1];
        end else begin
            shifted   = {1'b0, result_q[W-1:1]};
            shift_out = result_q[0];
        end
    end

    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        equal_d   = equal_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    left_d = (op == OP_LSH);
                    if (op[3]) begin
                        result_d  = '0;
                        cout_d    = 1'b0;
                        zero_d    = 1'b1;
                        equal_d   = 1'b0;
                        illegal_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (is_shift && (amt != '0)) begin
                        result_d = a;
                        cnt_d    = amt_clamped;
                        state_d  = S_SHIFT;
                    end else begin
                        result_d  = res_n;
                        cout_d    = cout_n;
                        zero_d    = (res_n == '0);
                        equal_d   = (op == OP_BRE) && (a == b);
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                result_d = shifted;
                cout_d   = shift_out;
                cnt_d    = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    zero_d    = (shifted == '0);
                    equal_d   = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            left_q    <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
            equal_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            zero_q    <= zero_d;
            equal_q   <= equal_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign cout    = cout_q;
    assign zero    = zero_q;
    assign equal   = equal_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised scoreboard bench for alu_seq_param (W=8) with directed corner cases.
module tb_alu_seq_param;
    localparam int W  = 8;
    localparam int SW = 4;

    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, zero, equal, illegal;
    logic [W-1:0] result;

    alu_seq_param #(.W(W), .SW(SW)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
        .equal(equal), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       e;
        logic       il;
        int         lat;
        int         done_cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour from the opcode definitions, using whole-number arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                   input logic ci);
        exp_t m;
        int k;
        int s;
        m.res = 8'h00; m.c = 1'b0; m.e = 1'b0; m.il = 1'b0; m.lat = 1; m.done_cyc = 0;
        if (o >= 8) begin
            m.il = 1'b1;
        end else begin
            case (o)
                4'd0, 4'd5: begin
                    k = int'(y) % 16;
                    if (k > 8) k = 8;
                    m.lat = 1 + k;
                    if (o == 4'd0) begin
                        s = int'(x) / (1 << k);
                        if (k > 0) m.c = x[k-1];
                    end else begin
                        s = (int'(x) * (1 << k)) % 256;
                        if (k > 0) m.c = x[8-k];
                    end
                    m.res = 8'(s);
                end
                4'd1: m.res = x ^ y;
                4'd2: begin
                    s = int'(x) + int'(y) + int'(ci);
                    m.res = 8'(s % 256);
                    m.c = (s >= 256);
                end
                4'd3: m.res = x & y;
                4'd4: begin
                    m.res = x ^ y;
                    m.e = (x == y);
                end
                4'd6: begin
                    s = int'(x) - int'(y);
                    if (s < 0) s = s + 256;
                    m.res = 8'(s);
                    m.c = (x < y);
                end
                default: m.res = 8'h00;
            endcase
        end
        m.z = (m.res == 8'h00);
        return m;
    endfunction

    always @(negedge CLK) begin
        if (!Reset && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("cout", 32'(cout), 32'(e.c));
                chk("zero", 32'(zero), 32'(e.z));
                chk("equal", 32'(equal), 32'(e.e));
                chk("illegal", 32'(illegal), 32'(e.il));
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input bit junk);
        exp_t m;
        wait_idle();
        m = model(o, x, y, ci);
        m.done_cyc = cyc + m.lat;
        q.push_back(m);
        op = o; a = x; b = y; cin = ci; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        while (cyc < m.done_cyc) begin
            if (junk) begin
                start = 1'($urandom_range(0, 1));
                op = 4'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            @(posedge CLK); #1;
        end
        start = 1'b0;
        wait_idle();
        chk("hold_result", 32'(result), 32'(m.res));
        chk("hold_zero", 32'(zero), 32'(m.z));
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_flags", 32'({cout, zero, equal, illegal}), 32'(0));
        Reset = 1'b0;
        @(posedge CLK); #1;
        chk("idle_result", 32'(result), 32'(0));

        issue(4'b0010, 8'hF0, 8'h20, 1'b1, 1'b0);
        issue(4'b0000, 8'h96, 8'h03, 1'b0, 1'b1);
        issue(4'b0101, 8'h81, 8'h09, 1'b0, 1'b0);
        issue(4'b0101, 8'h81, 8'h00, 1'b0, 1'b0);
        issue(4'b0100, 8'h5A, 8'h5A, 1'b0, 1'b0);
        issue(4'b0110, 8'h03, 8'h05, 1'b1, 1'b0);
        issue(4'b1010, 8'h33, 8'h44, 1'b0, 1'b0);
        issue(4'b0000, 8'hA5, 8'h0F, 1'b0, 1'b0);

        // Reset mid-shift: the aborted operation must not complete.
        wait_idle();
        op = 4'b0000; a = 8'hFF; b = 8'h06; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("abort_busy_before", 32'(busy), 32'(1));
        Reset = 1'b1;
        @(posedge CLK); #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        Reset = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("abort_no_done_pending", 32'(busy), 32'(0));
        issue(4'b0010, 8'h01, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] ro;
            logic [7:0] rb;
            ro = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
            rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            issue(ro, 8'($urandom), rb, 1'($urandom), 1'($urandom));
        end

        repeat (4) @(posedge CLK);
        #1;
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
